// File: rtl/p09_ball.sv
// p09_ball: ball object generator for the breakout game.
//
// Keeps the ball position and velocity, advances them once per frame
// (frame_tick) with wall, paddle and block bounces, and tracks the
// serve / in-flight / lost states. It also produces the registered
// per-pixel ball_en / ball pair for the priority video mux.
//
// Ports:
//   clk        in   pixel clock
//   reset      in   asynchronous, active-high reset
//   hpos/vpos  in   current pixel column / row (10 bit)
//   frame_tick in   one-cycle pulse per frame, in vertical blanking
//   paddle_x   in   paddle left edge (10 bit)
//   blocks_en  in   block-stage pixel enable, aligned with ball_en
//   serve      in   launch request (level)
//   ball_en    out  current pixel is inside the ball (1-cycle latency)
//   ball       out  ball colour when ball_en, else 0
//   lost       out  one-cycle pulse when the ball leaves the bottom
//   ball_x/y   out  ball top-left position (10 bit)
module p09_ball #(
    parameter int         BALL_SIZE    = 8,
    parameter int         SPEED        = 2,
    parameter int         FIELD_LEFT   = 8,
    parameter int         FIELD_RIGHT  = 632,
    parameter int         FIELD_TOP    = 8,
    parameter int         PADDLE_Y     = 440,
    parameter int         PADDLE_W     = 64,
    parameter int         FIELD_BOTTOM = 480,
    parameter logic [5:0] BALL_COLOR   = 6'b111111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       frame_tick,
    input  logic [9:0] paddle_x,
    input  logic       blocks_en,
    input  logic       serve,
    output logic       ball_en,
    output logic [5:0] ball,
    output logic       lost,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y
);

    typedef enum logic [1:0] {IDLE, MOVING, LOST} state_t;

    // Parking position on the paddle; reset parks at the field centre.
    localparam logic [9:0] PARK_Y   = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0] PARK_OFS = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0] RESET_X  = 10'((FIELD_LEFT + FIELD_RIGHT) / 2 - BALL_SIZE / 2);

    // Motion maths runs in 11-bit signed so a step never wraps.
    localparam logic signed [10:0] SPD    = 11'(SPEED);
    localparam logic signed [10:0] BSZ    = 11'(BALL_SIZE);
    localparam logic signed [10:0] S_LEFT = 11'(FIELD_LEFT);
    localparam logic signed [10:0] S_RGT  = 11'(FIELD_RIGHT);
    localparam logic signed [10:0] S_TOP  = 11'(FIELD_TOP);
    localparam logic signed [10:0] S_BOT  = 11'(FIELD_BOTTOM);
    localparam logic signed [10:0] S_PADY = 11'(PADDLE_Y);
    localparam logic signed [10:0] S_PADW = 11'(PADDLE_W);

    function automatic logic signed [10:0] to_s11(input logic [9:0] v);
        return signed'({1'b0, v});
    endfunction

    // pos lies within [org, org+BALL_SIZE); pos < org is rejected
    // explicitly so the wrapped difference cannot produce a hit.
    function automatic logic in_span(input logic [9:0] pos, input logic [9:0] org);
        logic [9:0] d;
        d = pos - org;
        return (pos >= org) && (d < 10'(BALL_SIZE));
    endfunction

    state_t state, state_n;
    logic [9:0] x_n, y_n;
    logic dx_neg, dx_neg_n;          // 1: moving left
    logic dy_neg, dy_neg_n;          // 1: moving up
    logic hit, hit_n;                // block hit seen since last tick
    logic lost_n;
    logic flip, dy_neg_eff;
    logic signed [10:0] bx_s, by_s, px_s, nx, ny;
    logic pix_on;

    always_comb begin
        state_n    = state;
        x_n        = ball_x;
        y_n        = ball_y;
        dx_neg_n   = dx_neg;
        dy_neg_n   = dy_neg;
        hit_n      = hit;
        lost_n     = 1'b0;

        bx_s       = to_s11(ball_x);
        by_s       = to_s11(ball_y);
        px_s       = to_s11(paddle_x);
        // A hit in the tick cycle itself counts as well as a latched one.
        flip       = hit || (ball_en && blocks_en);
        dy_neg_eff = dy_neg ^ flip;
        nx         = bx_s + (dx_neg ? -SPD : SPD);
        ny         = by_s + (dy_neg_eff ? -SPD : SPD);

        if (state == MOVING && ball_en && blocks_en)
            hit_n = 1'b1;

        if (frame_tick) begin
            unique case (state)
                IDLE: begin
                    x_n = paddle_x + PARK_OFS;
                    y_n = PARK_Y;
                    if (serve) begin
                        state_n  = MOVING;
                        dx_neg_n = 1'b0;
                        dy_neg_n = 1'b1;
                    end
                end
                MOVING: begin
                    dy_neg_n = dy_neg_eff;
                    if (nx <= S_LEFT) begin
                        x_n      = 10'(FIELD_LEFT);
                        dx_neg_n = 1'b0;
                    end else if (nx + BSZ >= S_RGT) begin
                        x_n      = 10'(FIELD_RIGHT - BALL_SIZE);
                        dx_neg_n = 1'b1;
                    end else begin
                        x_n = nx[9:0];
                    end

                    // Paddle test uses the pre-move x and the post-flip dy.
                    if (ny <= S_TOP) begin
                        y_n      = 10'(FIELD_TOP);
                        dy_neg_n = 1'b0;
                    end else if (!dy_neg_eff && (by_s + BSZ <= S_PADY) && (S_PADY <= ny + BSZ)
                                 && (bx_s + BSZ > px_s) && (bx_s < px_s + S_PADW)) begin
                        y_n      = PARK_Y;
                        dy_neg_n = 1'b1;
                    end else if (ny >= S_BOT) begin
                        state_n  = LOST;
                        lost_n   = 1'b1;
                        x_n      = ball_x;
                        y_n      = ball_y;
                        dx_neg_n = dx_neg;
                    end else begin
                        y_n = ny[9:0];
                    end
                    hit_n = 1'b0;
                end
                LOST: begin
                    state_n = IDLE;
                    x_n     = paddle_x + PARK_OFS;
                    y_n     = PARK_Y;
                end
                default: state_n = IDLE;
            endcase
        end

        if (state != MOVING)
            hit_n = 1'b0;
    end

    assign pix_on = in_span(hpos, ball_x) && in_span(vpos, ball_y) && (state != LOST);

    // Frame-rate state and motion registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ball_x <= RESET_X;
            ball_y <= PARK_Y;
            dx_neg <= 1'b0;
            dy_neg <= 1'b1;
            hit    <= 1'b0;
            lost   <= 1'b0;
        end else begin
            state  <= state_n;
            ball_x <= x_n;
            ball_y <= y_n;
            dx_neg <= dx_neg_n;
            dy_neg <= dy_neg_n;
            hit    <= hit_n;
            lost   <= lost_n;
        end
    end

    // Pixel stage: one clock behind hpos/vpos
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ball_en <= 1'b0;
            ball    <= 6'd0;
        end else begin
            ball_en <= pix_on;
            ball    <= pix_on ? BALL_COLOR : 6'd0;
        end
    end

endmodule

// File: tb/tb_p09_ball.sv
module tb_p09_ball;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos, vpos, paddle_x;
    logic       frame_tick, blocks_en, serve;
    logic       ball_en, lost;
    logic [5:0] ball;
    logic [9:0] ball_x, ball_y;

    int n_chk = 0;
    int n_bad = 0;

    p09_ball dut (
        .clk       (clk),
        .reset     (reset),
        .hpos      (hpos),
        .vpos      (vpos),
        .frame_tick(frame_tick),
        .paddle_x  (paddle_x),
        .blocks_en (blocks_en),
        .serve     (serve),
        .ball_en   (ball_en),
        .ball      (ball),
        .lost      (lost),
        .ball_x    (ball_x),
        .ball_y    (ball_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pix(input logic [9:0] h, input logic [9:0] v);
        hpos = h;
        vpos = v;
        step();
    endtask

    initial begin
        reset = 1'b1; hpos = 10'd0; vpos = 10'd0; paddle_x = 10'd288;
        frame_tick = 1'b0; blocks_en = 1'b0; serve = 1'b0;
        #1;
        chk("rst_x", 16'(ball_x), 16'd316);
        chk("rst_y", 16'(ball_y), 16'd432);
        chk("rst_en", 16'(ball_en), 16'd0);
        chk("rst_lost", 16'(lost), 16'd0);
        step(); step();
        reset = 1'b0;

        // Pixel scan of the parked ball, 1-cycle latency
        pix(10'd316, 10'd432); chk("pix_tl", 16'(ball_en), 16'd1);
        chk("pix_col", 16'(ball), 16'd63);
        pix(10'd323, 10'd439); chk("pix_br", 16'(ball_en), 16'd1);
        pix(10'd324, 10'd435); chk("pix_r_out", 16'(ball_en), 16'd0);
        chk("pix_col0", 16'(ball), 16'd0);
        pix(10'd315, 10'd435); chk("pix_l_out", 16'(ball_en), 16'd0);
        pix(10'd320, 10'd440); chk("pix_b_out", 16'(ball_en), 16'd0);
        pix(10'd0, 10'd0);

        // Park on paddle, serve, first move
        paddle_x = 10'd100;
        tick(); chk("park_x", 16'(ball_x), 16'd128);
        serve = 1'b1;
        tick(); chk("srv_x", 16'(ball_x), 16'd128);
        chk("srv_y", 16'(ball_y), 16'd432);
        serve = 1'b0;
        tick(); chk("mv1_x", 16'(ball_x), 16'd130);
        chk("mv1_y", 16'(ball_y), 16'd430);

        // Up-right to the top wall
        ticks(210); chk("up_y", 16'(ball_y), 16'd10);
        chk("up_x", 16'(ball_x), 16'd550);
        tick(); chk("top_y", 16'(ball_y), 16'd8);
        chk("top_x", 16'(ball_x), 16'd552);
        tick(); chk("topb_y", 16'(ball_y), 16'd10);

        // Down-right to the right wall
        ticks(34); chk("rw_pre_x", 16'(ball_x), 16'd622);
        tick(); chk("rw_x", 16'(ball_x), 16'd624);
        chk("rw_y", 16'(ball_y), 16'd80);
        tick(); chk("rwb_x", 16'(ball_x), 16'd622);

        // Down-left onto the paddle
        ticks(174); chk("dn_y", 16'(ball_y), 16'd430);
        chk("dn_x", 16'(ball_x), 16'd274);
        paddle_x = 10'd250;
        tick(); chk("pad_y", 16'(ball_y), 16'd432);
        chk("pad_x", 16'(ball_x), 16'd272);
        paddle_x = 10'd400;
        tick(); chk("padb_y", 16'(ball_y), 16'd430);
        chk("padb_x", 16'(ball_x), 16'd270);

        // Block hit mid-frame flips dy on the next tick
        pix(10'd270, 10'd430); chk("blk_en", 16'(ball_en), 16'd1);
        blocks_en = 1'b1;
        step();
        blocks_en = 1'b0;
        hpos = 10'd0; vpos = 10'd0;
        step();
        tick(); chk("blk_y", 16'(ball_y), 16'd432);
        chk("blk_x", 16'(ball_x), 16'd268);
        tick(); chk("blk_clr_y", 16'(ball_y), 16'd434);

        // Paddle missed: fall out the bottom
        ticks(22); chk("fall_y", 16'(ball_y), 16'd478);
        chk("fall_lost0", 16'(lost), 16'd0);
        tick(); chk("lost_pulse", 16'(lost), 16'd1);
        chk("lost_hold_y", 16'(ball_y), 16'd478);
        step(); chk("lost_end", 16'(lost), 16'd0);
        pix(10'd222, 10'd478); chk("lost_pix", 16'(ball_en), 16'd0);
        pix(10'd0, 10'd0);

        // LOST ignores serve and returns to IDLE parked
        paddle_x = 10'd100;
        serve = 1'b1;
        tick(); chk("ret_x", 16'(ball_x), 16'd128);
        chk("ret_y", 16'(ball_y), 16'd432);
        serve = 1'b0;
        tick(); chk("ret_idle_y", 16'(ball_y), 16'd432);

        // Asynchronous reset in flight
        serve = 1'b1;
        tick();
        serve = 1'b0;
        ticks(2); chk("fl_x", 16'(ball_x), 16'd132);
        chk("fl_y", 16'(ball_y), 16'd428);
        pix(10'd132, 10'd428); chk("fl_en", 16'(ball_en), 16'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_x", 16'(ball_x), 16'd316);
        chk("ar_y", 16'(ball_y), 16'd432);
        chk("ar_en", 16'(ball_en), 16'd0);
        step();
        reset = 1'b0;
        hpos = 10'd0; vpos = 10'd0;
        tick(); chk("ar_park_x", 16'(ball_x), 16'd128);
        tick(); chk("ar_idle_y", 16'(ball_y), 16'd432);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/p09_ball.md
# p09_ball

Ball-object generator for the breakout game. It keeps the ball position and velocity, updates them once per frame with wall, paddle and block bounces, and tracks serve and lost-ball states. It also produces the per-pixel `ball_en` / `ball` pair that feeds the ball input of the priority video mux directly downstream.

## Interface
- `BALL_SIZE`, 8: ball edge length in pixels (square ball).
- `SPEED`, 2: pixels moved per frame on each axis.
- `FIELD_LEFT`, 8 / `FIELD_RIGHT`, 632 / `FIELD_TOP`, 8: inner edges of the border.
- `PADDLE_Y`, 440: top row of the paddle.
- `PADDLE_W`, 64: paddle width in pixels.
- `FIELD_BOTTOM`, 480: the ball is lost when its top row reaches this row.
- `BALL_COLOR`, 6'b111111: RRGGBB colour driven on `ball`.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `hpos`  in  10  current pixel column.
- `vpos`  in  10  current pixel row.
- `frame_tick`  in  1  one-cycle pulse, once per frame, during vertical blanking.
- `paddle_x`  in  10  paddle left edge, stable around `frame_tick`.
- `blocks_en`  in  1  block-stage pixel enable, aligned with `ball_en`.
- `serve`  in  1  launch request (level).
- `ball_en`  out  1  current pixel is inside the ball (registered).
- `ball`  out  6  ball colour; `BALL_COLOR` when `ball_en`, else 0.
- `lost`  out  1  one-cycle pulse when the ball leaves the bottom.
- `ball_x`, `ball_y`  out  10 each  ball top-left position.

## Operation
- States:
  - IDLE: ball parked on the paddle.
  - MOVING: ball in flight.
  - LOST: ball gone, waiting for the next frame.
- Reset values (asynchronous, take effect immediately):
  - state IDLE
  - `ball_x`=316, `ball_y`=`PADDLE_Y-BALL_SIZE`=432
  - dx=+`SPEED`, dy=-`SPEED`
  - hit latch 0
  - `ball_en`, `ball`, `lost` all 0
- All position and velocity updates happen only in the cycle where `frame_tick`=1.
- IDLE:
  - On each tick, `ball_x` = `paddle_x + PADDLE_W/2 - BALL_SIZE/2` and `ball_y`=432.
  - If `serve`=1 on the tick, go to MOVING with dx=+`SPEED`, dy=-`SPEED`. Position is still set as above; movement starts on the next tick.
- MOVING, per tick, in this order:
  1. If the hit latch is set (or `ball_en && blocks_en` in the tick cycle itself), negate dy.
  2. Compute nx=`ball_x`+dx and ny=`ball_y`+dy in 11-bit signed arithmetic. No 10-bit wrap is permitted.
  3. Horizontal:
     - nx ≤ `FIELD_LEFT`: `ball_x`=`FIELD_LEFT`, dx=+`SPEED`.
     - nx+`BALL_SIZE` ≥ `FIELD_RIGHT`: `ball_x`=`FIELD_RIGHT-BALL_SIZE`, dx=-`SPEED`.
     - Otherwise `ball_x`=nx.
  4. Vertical:
     - ny ≤ `FIELD_TOP`: `ball_y`=`FIELD_TOP`, dy=+`SPEED`.
     - Paddle bounce applies when all of the following hold: dy>0, `ball_y+BALL_SIZE` ≤ `PADDLE_Y` ≤ `ny+BALL_SIZE`, and horizontal overlap (`ball_x+BALL_SIZE` > `paddle_x` and `ball_x` < `paddle_x+PADDLE_W`, using the pre-move `ball_x`). Then `ball_y`=`PADDLE_Y-BALL_SIZE`, dy=-`SPEED`.
     - ny ≥ `FIELD_BOTTOM`: go to LOST and pulse `lost` for one cycle. Position is held.
     - Otherwise `ball_y`=ny.
  5. Clear the hit latch.
- Hit latch: set in MOVING in any cycle where `ball_en && blocks_en`. Only cleared on a tick. In IDLE and LOST it is held at 0.
- LOST: on the next tick, go to IDLE (with the IDLE parking position applied on that same tick). `serve` is ignored in LOST.
- Pixel output:
  - `ball_en` is registered as (`hpos` − `ball_x`) < `BALL_SIZE` and (`vpos` − `ball_y`) < `BALL_SIZE`, unsigned 10-bit compare, guarded so that hpos < ball_x gives 0.
  - `ball_en` is forced to 0 in LOST.
  - `ball` = `ball_en` ? `BALL_COLOR` : 0.

## Timing
- `ball_en` / `ball` lag `hpos`/`vpos` by exactly 1 clock. All sibling object generators present the same 1-cycle latency to the mux.
- Position and state change on the clock edge ending the `frame_tick` cycle. New values are visible from the following cycle.
- `lost` is high for exactly the cycle after the tick that detected the loss.
- Simultaneous events:
  - A block hit and a wall hit in the same frame both apply: dy negates, then the wall clamp applies.
  - A block hit and a paddle contact: the block flip applies first. The paddle check then requires dy>0 after the flip.
  - Corner contact (x and y limits in one tick) clamps and reflects both axes.
- `reset` asserted mid-frame forces all reset values within the same cycle, with no tick required. Operation resumes on the first tick after release.

## Test plan
- Reset → `ball_x`=316, `ball_y`=432, `ball_en`=0, `lost`=0; scanning hpos 316..323 / vpos 432..439 gives `ball_en`=1 one clock later, 0 at hpos 324.
- IDLE with `paddle_x`=100, one tick → `ball_x`=128; `serve`=1 on the next tick → MOVING; after one further tick `ball_x`=130, `ball_y`=430.
- Ball at x=622 moving right (dx=+2) → tick gives nx=624 ≥ 624 → `ball_x`=624, dx=-2; at y=10 with dy=-2 → `ball_y`=8, dy=+2.
- Ball at y=431, dy=+2, x=200, `paddle_x`=180 → `ball_y`=432, dy=-2; same with `paddle_x`=300 → ball falls, reaching y≥480 pulses `lost` for 1 cycle, state LOST, IDLE after the next tick.
- Drive `blocks_en`=1 while `ball_en`=1 mid-frame, dy=-2, y=200 → next tick `ball_y`=202, dy=+2; hit latch clear afterwards.
- Assert `reset` for 1 cycle mid-flight at arbitrary hpos → outputs and position return to reset values immediately; `serve` is needed again to move.
